// File: rtl/siso_shift_sequencer.sv
// siso_shift_sequencer
//   Serialises a WIDTH-bit word LSB-first through a SISO shift register,
//   holding each bit for BIT_CYCLES clocks and flagging frame boundaries.
//   Optional feature macro: PARITY_EN appends one even-parity bit per frame.
// Ports
//   clk, reset         clock / async active-high reset
//   in_valid_i         producer has a word on in_data_i
//   in_data_i          parallel word, sampled at the handshake edge
//   in_ready_o         high in IDLE only
//   sdo_o, sdo_valid_o serial data and its qualifier
//   frame_start_o      first cycle of bit 0
//   frame_done_o       last cycle of the final frame bit
//   bit_idx_o          index of the bit on sdo_o, 0 when idle
module siso_shift_sequencer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       sdo_o,
  output logic                       sdo_valid_o,
  output logic                       frame_start_o,
  output logic                       frame_done_o,
  output logic [$clog2(WIDTH+1)-1:0] bit_idx_o
);
  localparam int BIDX_W = $clog2(WIDTH+1);
  localparam int DIV_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIDX_W-1:0]  bit_q, bit_d;
  logic               tc, last_data;
`ifdef PARITY_EN
  logic               par_q, par_d;
`endif

  // With BIT_CYCLES=1 this compare is constantly true.
  assign tc        = (div_q == DIV_W'(BIT_CYCLES-1));
  assign last_data = (bit_q == BIDX_W'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = SHIFT;
          sreg_d  = in_data_i;
          div_d   = '0;
          bit_d   = '0;
`ifdef PARITY_EN
          par_d   = ^in_data_i;
`endif
        end
      end
      SHIFT: begin
        if (tc) begin
          div_d  = '0;
          sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          if (last_data) begin
`ifdef PARITY_EN
            state_d = PARITY;
            bit_d   = bit_q + 1'b1;  // parity bit reports index WIDTH
`else
            state_d = IDLE;
            bit_d   = '0;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (tc) begin
          state_d = IDLE;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; nothing feeds through from inputs.
  assign in_ready_o    = (state_q == IDLE);
  assign sdo_valid_o   = (state_q != IDLE);
  assign frame_start_o = (state_q == SHIFT) && (bit_q == '0) && (div_q == '0);
  assign bit_idx_o     = bit_q;
`ifdef PARITY_EN
  assign sdo_o        = (state_q == SHIFT)  ? sreg_q[0] :
                        (state_q == PARITY) ? par_q : 1'b0;
  assign frame_done_o = (state_q == PARITY) && tc;
`else
  assign sdo_o        = (state_q == SHIFT) ? sreg_q[0] : 1'b0;
  assign frame_done_o = (state_q == SHIFT) && last_data && tc;
`endif

endmodule

// File: doc/siso_shift_sequencer.md
# siso_shift_sequencer

Controller that serialises parallel words through the team's SISO shift-register chain of D flip-flops. Accepts a word on a valid/ready handshake, loads it into a WIDTH-bit shift register, shifts it out LSB-first with a programmable bit period, and signals frame boundaries. It sits between a parallel producer and any serial consumer built on the SISO datapath.

## Interface
- WIDTH, 8: data word width in bits; legal range is WIDTH >= 2.
- BIT_CYCLES, 1: clock cycles each serial bit is held; legal range is BIT_CYCLES >= 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset; asynchronous, active-high.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  WIDTH  parallel word; sampled only at the handshake edge.
- in_ready  out  1  sequencer can accept a word (IDLE only).
- sdo  out  1  serial data out.
- sdo_valid  out  1  sdo carries a frame bit.
- frame_start  out  1  one-cycle pulse on the first cycle of bit 0.
- frame_done  out  1  one-cycle pulse on the last cycle of the final bit.
- bit_idx  out  $clog2(WIDTH+1)  index of the bit currently on sdo; 0 when idle.

## Operation
- State machine states: IDLE, SHIFT, PARITY. PARITY exists only with PARITY_EN.
- IDLE:
  - in_ready=1; sdo=0; sdo_valid=0; bit_idx=0.
  - Handshake occurs when in_valid && in_ready is sampled at a rising edge.
  - At the handshake edge: the shift register loads in_data, the bit counter clears, the cycle divider clears, and the state moves to SHIFT.
- SHIFT:
  - sdo = shift register bit 0; sdo_valid=1.
  - The divider counts 0..BIT_CYCLES-1. At the divider terminal count, the register shifts right by one (0 fills the MSB) and bit_idx increments.
  - After bit WIDTH-1 reaches terminal count: move to PARITY if PARITY_EN is defined, otherwise to IDLE.
- PARITY: sdo = XOR of the captured word (even parity), held for one bit period, then move to IDLE.
- frame_done asserts during the terminal-count cycle of the last frame bit.
- in_data is don't-care outside the handshake cycle. in_valid may be withdrawn at any time without effect.
- All outputs are registered or derived from registered state only. There is no combinational path from the inputs to the outputs.
- Reset mid-frame:
  - Aborts the frame immediately.
  - All outputs go to their reset values; no frame_done pulse is produced.
  - The partial word is discarded.
- Output reset values: in_ready=1, sdo=0, sdo_valid=0, frame_start=0, frame_done=0, bit_idx=0.

## Timing
- Handshake at edge k: the first bit appears on sdo, with frame_start=1, in cycle k+1.
- Frame length is NB × BIT_CYCLES cycles, where NB = WIDTH, or WIDTH+1 with PARITY_EN.
- frame_done is high in the final cycle of the frame. in_ready returns to 1 in the following cycle.
- Back-to-back words with in_valid held high: exactly one IDLE (handshake) cycle between frames.
- sdo and bit_idx change only at bit-period boundaries and are stable within a bit period.
- With BIT_CYCLES=1, the divider is always at terminal count.

## Configuration
- PARITY_EN defined:
  - Appends one even-parity bit after the data bits.
  - Frame length becomes WIDTH+1 bits.
  - bit_idx reaches WIDTH during the parity bit.
- PARITY_EN undefined:
  - The PARITY state and parity logic are absent.
  - Frame length is WIDTH bits.
  - bit_idx maximum is WIDTH-1.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> outputs immediately in_ready=1, sdo=0, sdo_valid=0, frame_start=0, frame_done=0, bit_idx=0.
- WIDTH=8, BIT_CYCLES=1, no parity: send 0xA5 at edge k -> sdo sequence 1,0,1,0,0,1,0,1 in cycles k+1..k+8; frame_start at k+1; frame_done at k+8; in_ready=1 at k+9.
- PARITY_EN: send 0xA5 -> 9th bit 0; send 0x07 -> 9th bit 1; frame_done moves to the parity cycle.
- BIT_CYCLES=3: send 0x01 -> sdo=1 for 3 cycles, then 0 for 21 cycles; bit_idx increments every 3 cycles; frame_done in cycle 24.
- Abort: assert reset during bit 4 of 0xFF, then send 0x3C -> no frame_done for the aborted word; 0x3C is serialised correctly.
- Back-to-back: hold in_valid high with 0x11 then 0x22 -> two complete frames separated by exactly one cycle with sdo_valid=0.
